// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB4 word-addressed memory slave with fixed wait states (optional APB_SLAVE_MEM_PROT_CHECK_EN)
module apb_slave_mem #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int WAIT_STATES   = 2
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic                      pwrite,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [2:0]                pprot,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int ALIGN = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LIMIT      = ADDRESS_WIDTH'(MEM_DEPTH * BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(BYTES - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]               state, state_n;
    logic [3:0]               cnt, cnt_n;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     write_q;
    logic [BYTES-1:0]         strb_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [2:0]               prot_q;

    logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

    logic                     setup;
    logic                     resp_n;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] eff_addr;
    logic                     eff_write;
    logic                     eff_err;
    logic                     lat_err;
    logic [IDX_W-1:0]         eff_idx;
    logic [IDX_W-1:0]         lat_idx;

    // Out-of-range or misaligned byte address.
    function automatic logic addr_err(input logic [ADDRESS_WIDTH-1:0] a);
        return (a >= LIMIT) || ((a & ALIGN_MASK) != '0);
    endfunction

`ifdef APB_SLAVE_MEM_PROT_CHECK_EN
    // Non-secure access into the upper half of the memory is refused.
    function automatic logic prot_err(input logic [ADDRESS_WIDTH-1:0] a, input logic [2:0] p);
        return p[1] && a[ALIGN + IDX_W - 1];
    endfunction

    logic [2:0] eff_prot;
    assign eff_prot = setup ? pprot : prot_q;
    assign eff_err  = addr_err(eff_addr) || prot_err(eff_addr, eff_prot);
    assign lat_err  = addr_err(addr_q) || prot_err(addr_q, prot_q);
`else
    logic unused_prot;
    assign unused_prot = ^prot_q;
    assign eff_err     = addr_err(eff_addr);
    assign lat_err     = addr_err(addr_q);
`endif

    // The response is registered, so it is prepared from the transfer that
    // will be in its completion cycle next: the live bus at setup (zero-wait
    // case) or the latched copy during wait states.
    assign eff_addr  = setup ? paddr : addr_q;
    assign eff_write = setup ? pwrite : write_q;
    assign eff_idx   = eff_addr[ALIGN +: IDX_W];
    assign lat_idx   = addr_q[ALIGN +: IDX_W];

    // Next-state, wait counter and "next cycle completes" decode.
    always_comb begin
        setup   = (state == IDLE) && psel && !penable;
        state_n = state;
        cnt_n   = cnt;
        if (state == IDLE) begin
            if (setup) begin
                state_n = ACCESS;
                cnt_n   = 4'(WAIT_STATES);
            end
        end else if (!psel) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (cnt != '0) begin
            cnt_n = cnt - 4'd1;
        end else begin
            state_n = IDLE;
        end
        resp_n = (state_n == ACCESS) && (cnt_n == '0);
    end

    // Commit happens at the edge closing the completion cycle.
    assign wr_en = !preset && (state == ACCESS) && psel && (cnt == '0)
                   && write_q && !lat_err;

    // FSM, transfer latches and registered response.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            prot_q  <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (setup) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                strb_q  <= pstrb;
                wdata_q <= pwdata;
                prot_q  <= pprot;
            end
            pready  <= resp_n;
            pslverr <= resp_n && eff_err;
            prdata  <= (resp_n && !eff_write && !eff_err) ? mem[eff_idx] : '0;
        end
    end

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge pclk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (strb_q[i]) begin
                    mem[lat_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed self-checking bench for apb_slave_mem
module tb_apb_slave_mem;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int tests = 0;
    int fails = 0;

    apb_slave_mem #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH(256),
        .WAIT_STATES(2)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .psel(psel),
        .penable(penable),
        .paddr(paddr),
        .pwrite(pwrite),
        .pstrb(pstrb),
        .pwdata(pwdata),
        .pprot(pprot),
        .pready(pready),
        .prdata(prdata),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Full transfer starting at a negedge; returns latency in cycles after setup.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p,
                        output logic [31:0] rd, output logic err, output int lat);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s; pprot = p;
        @(negedge pclk);
        penable = 1'b1;
        lat = 1;
        while (!pready && lat < 20) begin
            @(negedge pclk);
            lat++;
        end
        if (!pready) begin
            tests++; fails++;
            $display("FAIL xfer_timeout addr=%h got no pready within %0d cycles", a, lat);
        end
        rd  = prdata;
        err = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        tests++; if (pready !== 1'b0) begin fails++; $display("FAIL reset_pready got %b want 0", pready); end
        tests++; if (prdata !== 32'h0) begin fails++; $display("FAIL reset_prdata got %h want 0", prdata); end
        tests++; if (pslverr !== 1'b0) begin fails++; $display("FAIL reset_pslverr got %b want 0", pslverr); end
        preset = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, rd, err, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL wr_latency got %0d want 3", lat); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL wr_pslverr got %b want 0", err); end
        tests++; if (pready !== 1'b0) begin fails++; $display("FAIL pready_after got %b want 0", pready); end
        @(negedge pclk);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL rd_latency got %0d want 3", lat); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got %h want deadbeef", rd); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rd_pslverr got %b want 0", err); end
        tests++; if (prdata !== 32'h0) begin fails++; $display("FAIL prdata_after got %h want 0", prdata); end
        @(negedge pclk);
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b000, rd, err, lat);
        xfer(1'b1, 32'h20, 32'h00000000, 4'b0101, 3'b000, rd, err, lat);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (rd !== 32'hFF00FF00) begin fails++; $display("FAIL strobe_data got %h want ff00ff00", rd); end
        xfer(1'b1, 32'h20, 32'h12345678, 4'h0, 3'b000, rd, err, lat);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL strobe0_pslverr got %b want 0", err); end
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (rd !== 32'hFF00FF00) begin fails++; $display("FAIL strobe0_data got %h want ff00ff00", rd); end
        @(negedge pclk);
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b0, 32'h400, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL range_pslverr got %b want 1", err); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL range_prdata got %h want 0", rd); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL range_latency got %0d want 3", lat); end
        xfer(1'b0, 32'h02, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL align_pslverr got %b want 1", err); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL align_prdata got %h want 0", rd); end
        xfer(1'b1, 32'h12, 32'h0, 4'hF, 3'b000, rd, err, lat);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL align_wr_pslverr got %b want 1", err); end
        xfer(1'b1, 32'h400, 32'h0, 4'hF, 3'b000, rd, err, lat);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL err_nowrite got %h want deadbeef", rd); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", err); end
        @(negedge pclk);
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 3'b000, rd, err, lat);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h11111111; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        tests++; if (pready !== 1'b0) begin fails++; $display("FAIL rst_mid_pready got %b want 0", pready); end
        tests++; if (pslverr !== 1'b0) begin fails++; $display("FAIL rst_mid_pslverr got %b want 0", pslverr); end
        tests++; if (prdata !== 32'h0) begin fails++; $display("FAIL rst_mid_prdata got %h want 0", prdata); end
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (2) @(negedge pclk);
        xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (rd !== 32'hA5A5A5A5) begin fails++; $display("FAIL rst_mid_keep got %h want a5a5a5a5", rd); end
        @(negedge pclk);
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int lat; int hits;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        hits = 0;
        repeat (4) begin
            @(negedge pclk);
            if (pready) hits++;
        end
        tests++; if (hits !== 0) begin fails++; $display("FAIL abort_pready got %0d pulses want 0", hits); end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL abort_next_latency got %0d want 3", lat); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL abort_nowrite got %h want deadbeef", rd); end
        @(negedge pclk);
    endtask

    task automatic test_sample_hold();
        logic [31:0] rd; logic err; int lat; int n;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h50; pwdata = 32'h01020304; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'h0;
        n = 0;
        while (!pready && n < 20) begin @(negedge pclk); n++; end
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        xfer(1'b0, 32'h50, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (rd !== 32'h01020304) begin fails++; $display("FAIL hold_data got %h want 01020304", rd); end
        @(negedge pclk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int lat; int hits;
        xfer(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 3'b000, rd, err, lat);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL b2b_latency got %0d want 3", lat); end
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL b2b_raw got %h want cafef00d", rd); end
        @(negedge pclk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h40;
        hits = 0;
        repeat (5) begin
            @(negedge pclk);
            if (pready) hits++;
        end
        psel = 1'b0; penable = 1'b0;
        tests++; if (hits !== 0) begin fails++; $display("FAIL idle_penable got %0d pulses want 0", hits); end
        @(negedge pclk);
    endtask

    task automatic test_prot();
        logic [31:0] rd; logic err; int lat;
        logic        exp_err;
        logic [31:0] exp_data;
`ifdef APB_SLAVE_MEM_PROT_CHECK_EN
        exp_err  = 1'b1;
        exp_data = 32'hAAAA5555;
`else
        exp_err  = 1'b0;
        exp_data = 32'h12345678;
`endif
        xfer(1'b1, 32'h320, 32'hAAAA5555, 4'hF, 3'b000, rd, err, lat);
        xfer(1'b1, 32'h320, 32'h12345678, 4'hF, 3'b010, rd, err, lat);
        tests++; if (err !== exp_err) begin fails++; $display("FAIL prot_pslverr got %b want %b", err, exp_err); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL prot_latency got %0d want 3", lat); end
        xfer(1'b0, 32'h320, 32'h0, 4'h0, 3'b000, rd, err, lat);
        tests++; if (rd !== exp_data) begin fails++; $display("FAIL prot_data got %h want %h", rd, exp_data); end
        xfer(1'b1, 32'h0C, 32'h0BADF00D, 4'hF, 3'b010, rd, err, lat);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL prot_lower_pslverr got %b want 0", err); end
        @(negedge pclk);
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
        pstrb = '0; pwdata = '0; pprot = '0;
        @(negedge pclk);
        test_reset();
        test_write_read();
        test_strobe();
        test_errors();
        test_reset_midwrite();
        test_abort();
        test_sample_hold();
        test_back_to_back();
        test_prot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
